// File: rtl/lane_pkg.sv
// Shared constants and state encoding for the lane scheduler.
package lane_pkg;

    localparam int              WORD_W_DEF     = 10;
    localparam logic [9:0]      IDLE_K28_5_RDN = 10'b0011111010;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/lane_arb.sv
// Two-requester arbiter, grants only while advance is high.
// LANE_SCHED_RR_EN selects round-robin; otherwise fixed priority req0 > req1.
module lane_arb (
`ifdef LANE_SCHED_RR_EN
    input  logic       reloj,
    input  logic       reset,
`endif
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

`ifdef LANE_SCHED_RR_EN
    // ptr_q: 0 prefers req0, 1 prefers req1; flips to the loser after each grant
    logic ptr_q, ptr_d;

    always_comb begin
        grant = 2'b00;
        ptr_d = ptr_q;
        if (advance) begin
            if (valid == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
            else                grant = valid;
            if (grant != 2'b00) ptr_d = grant[0];
        end
    end

    always_ff @(posedge reloj) begin
        if (reset) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end
`else
    always_comb begin
        grant = 2'b00;
        if (advance) grant = valid[0] ? 2'b01 : {valid[1], 1'b0};
    end
`endif

endmodule

// File: rtl/lane_sched.sv
// Serial-lane word scheduler: comma sync on link enable, then arbitrated data words.
// Arbitration policy set by macro LANE_SCHED_RR_EN (see lane_arb).
module lane_sched
    import lane_pkg::*;
#(
    parameter int                WORD_W     = WORD_W_DEF,
    parameter int                SYNC_WORDS = 4,
    parameter logic [WORD_W-1:0] IDLE_WORD  = IDLE_K28_5_RDN
) (
    input  logic              reloj,
    input  logic              reset,
    input  logic              link_en,
    input  logic              req0_valid,
    input  logic              req1_valid,
    input  logic [WORD_W-1:0] req0_data,
    input  logic [WORD_W-1:0] req1_data,
    output logic              req0_ready,
    output logic              req1_ready,
    output logic              ser_load,
    output logic [WORD_W-1:0] ser_word,
    output logic              link_up,
    output logic [15:0]       word_cnt
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    state_e            state_q, state_d;
    logic [3:0]        sync_cnt_q, sync_cnt_d;
    logic [WORD_W-1:0] ser_word_q, ser_word_d;
    logic              ser_load_q, ser_load_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic              boundary;
    logic              slot;
    logic [1:0]        grant;

    assign boundary = (cnt_q == CNT_W'(WORD_W - 1));
    assign slot     = boundary && link_en && (state_q == ST_RUN);

    lane_arb u_arb (
`ifdef LANE_SCHED_RR_EN
        .reloj   (reloj),
        .reset   (reset),
`endif
        .valid   ({req1_valid, req0_valid}),
        .advance (slot),
        .grant   (grant)
    );

    // The comma loaded on the OFF->SYNC boundary is the first sync word, so
    // sync_cnt counts the commas sent after it.
    always_comb begin
        cnt_d      = boundary ? '0 : cnt_q + CNT_W'(1);
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        ser_word_d = ser_word_q;
        ser_load_d = 1'b0;
        word_cnt_d = word_cnt_q + 16'(grant != 2'b00);
        if (boundary) begin
            if (!link_en) begin
                state_d = ST_OFF;
            end else begin
                case (state_q)
                    ST_OFF: begin
                        ser_load_d = 1'b1;
                        ser_word_d = IDLE_WORD;
                        sync_cnt_d = 4'd0;
                        state_d    = (SYNC_WORDS == 1) ? ST_RUN : ST_SYNC;
                    end
                    ST_SYNC: begin
                        ser_load_d = 1'b1;
                        ser_word_d = IDLE_WORD;
                        sync_cnt_d = sync_cnt_q + 4'd1;
                        if (sync_cnt_q + 4'd1 == 4'(SYNC_WORDS - 1)) state_d = ST_RUN;
                    end
                    ST_RUN: begin
                        ser_load_d = 1'b1;
                        if (grant[0])      ser_word_d = req0_data;
                        else if (grant[1]) ser_word_d = req1_data;
                        else               ser_word_d = IDLE_WORD;
                    end
                    default: state_d = ST_OFF;
                endcase
            end
        end
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            cnt_q      <= '0;
            state_q    <= ST_OFF;
            sync_cnt_q <= 4'd0;
            ser_word_q <= '0;
            ser_load_q <= 1'b0;
            word_cnt_q <= 16'd0;
        end else begin
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            ser_word_q <= ser_word_d;
            ser_load_q <= ser_load_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign ser_load   = ser_load_q;
    assign ser_word   = ser_word_q;
    assign link_up    = (state_q == ST_RUN);
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_lane_sched.sv
// Directed bench for lane_sched: sync sequence, arbitration, link drop, reset, word_cnt wrap.
`timescale 1ns/1ps
module tb_lane_sched;

    localparam logic [9:0] IDLE = 10'b0011111010;

    logic       reloj = 1'b0;
    logic       reset, link_en, req0_valid, req1_valid;
    logic [9:0] req0_data, req1_data;
    logic       req0_ready, req1_ready, ser_load, link_up;
    logic [9:0] ser_word;
    logic [15:0] word_cnt;

    // second instance, one-bit words: a boundary every cycle makes the 16-bit wrap reachable
    logic       w_reset, w_link_en, w_v0, w_d0, w_r0, w_r1, w_load, w_word, w_link;
    logic [15:0] w_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_xfer   = 0;

    always #5 reloj = ~reloj;

    lane_sched u_dut (
        .reloj(reloj), .reset(reset), .link_en(link_en),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .ser_load(ser_load), .ser_word(ser_word),
        .link_up(link_up), .word_cnt(word_cnt)
    );

    lane_sched #(.WORD_W(1), .SYNC_WORDS(1), .IDLE_WORD(1'b1)) u_wrap (
        .reloj(reloj), .reset(w_reset), .link_en(w_link_en),
        .req0_valid(w_v0), .req1_valid(1'b0),
        .req0_data(w_d0), .req1_data(1'b0),
        .req0_ready(w_r0), .req1_ready(w_r1),
        .ser_load(w_load), .ser_word(w_word),
        .link_up(w_link), .word_cnt(w_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge reloj);
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    // commas expected at first_load + 0/10/20/30, link_up from the last one onward
    task automatic sync_check(input int first_load);
        logic exp_load;
        while (cyc < first_load + 30) begin
            step();
            exp_load = (cyc >= first_load) && ((cyc - first_load) % 10 == 0);
            chk("sync_load", ser_load, exp_load);
            if (exp_load) chk("sync_word", ser_word, IDLE);
            chk("sync_link_up", link_up, cyc >= first_load + 30);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ser_load"}, ser_load, 1'b0);
        chk({tag, "_ser_word"}, ser_word, 10'h0);
        chk({tag, "_ready0"},   req0_ready, 1'b0);
        chk({tag, "_ready1"},   req1_ready, 1'b0);
        chk({tag, "_link_up"},  link_up, 1'b0);
        chk({tag, "_word_cnt"}, word_cnt, 16'h0);
    endtask

    initial begin
        reset = 1'b1; link_en = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 10'h155; req1_data = 10'h2AA;
        w_reset = 1'b1; w_link_en = 1'b0; w_v0 = 1'b0; w_d0 = 1'b0;

        // reset dominates even with every input asserted
        repeat (3) @(negedge reloj);
        chk_reset_vals("rst");

        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;
        cyc = 1;
        sync_check(11);

        // RUN, nothing valid: comma filler, no count
        goto(50);
        chk("idle_rdy0", req0_ready, 1'b0);
        chk("idle_rdy1", req1_ready, 1'b0);
        goto(51);
        chk("idle_load", ser_load, 1'b1);
        chk("idle_word", ser_word, IDLE);
        chk("idle_cnt",  word_cnt, 16'd0);

        req0_valid = 1'b1; req1_valid = 1'b1;
        goto(55);
        chk("mid_rdy0", req0_ready, 1'b0);
        chk("mid_rdy1", req1_ready, 1'b0);
        goto(60);
        chk("b60_rdy0", req0_ready, 1'b1);
        chk("b60_rdy1", req1_ready, 1'b0);
        goto(61);
        chk("b60_load", ser_load, 1'b1);
        chk("b60_word", ser_word, 10'h155);
        chk("b60_cnt",  word_cnt, 16'd1);
        goto(70);
`ifdef LANE_SCHED_RR_EN
        chk("b70_rdy0", req0_ready, 1'b0);
        chk("b70_rdy1", req1_ready, 1'b1);
        goto(71);
        chk("b70_word", ser_word, 10'h2AA);
`else
        chk("b70_rdy0", req0_ready, 1'b1);
        chk("b70_rdy1", req1_ready, 1'b0);
        goto(71);
        chk("b70_word", ser_word, 10'h155);
`endif
        chk("b70_cnt", word_cnt, 16'd2);
        goto(80);
        chk("b80_rdy0", req0_ready, 1'b1);
        chk("b80_rdy1", req1_ready, 1'b0);
        goto(81);
        chk("b80_word", ser_word, 10'h155);
        chk("b80_cnt",  word_cnt, 16'd3);

        // only req1 valid: it wins on two consecutive boundaries
        req0_valid = 1'b0;
        goto(90);
        chk("b90_rdy0", req0_ready, 1'b0);
        chk("b90_rdy1", req1_ready, 1'b1);
        goto(91);
        chk("b90_word", ser_word, 10'h2AA);
        goto(100);
        chk("b100_rdy1", req1_ready, 1'b1);
        goto(101);
        chk("b100_word", ser_word, 10'h2AA);
        chk("b100_cnt",  word_cnt, 16'd5);

        // link dropped mid-word with req0 pending
        req0_valid = 1'b1; req1_valid = 1'b0;
        goto(105);
        link_en = 1'b0;
        goto(110);
        chk("drop_rdy0", req0_ready, 1'b0);
        goto(111);
        chk("drop_load",    ser_load, 1'b0);
        chk("drop_link_up", link_up, 1'b0);
        chk("drop_word",    ser_word, 10'h2AA);
        chk("drop_cnt",     word_cnt, 16'd5);
        link_en = 1'b1; req0_valid = 1'b0;
        sync_check(121);

        // back to OFF, re-enable, reset after two commas
        link_en = 1'b0;
        goto(161);
        chk("off_link_up", link_up, 1'b0);
        link_en = 1'b1;
        goto(171);
        chk("comma1_load", ser_load, 1'b1);
        goto(181);
        chk("comma2_load", ser_load, 1'b1);
        goto(185);
        reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        step();
        chk_reset_vals("sync_rst");
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        cyc = 1;
        sync_check(11);

        // word_cnt wrap on the one-bit instance
        w_reset = 1'b0; w_link_en = 1'b1; w_v0 = 1'b1;
        n_xfer = 0;
        if (w_r0) n_xfer++;
        for (int i = 0; i < 70000; i++) begin
            @(negedge reloj);
            if (n_xfer == 65535) break;
            if (w_r0) n_xfer++;
        end
        chk("wrap_xfers",   n_xfer, 65535);
        chk("wrap_cnt_max", w_cnt, 16'hFFFF);
        chk("wrap_rdy0",    w_r0, 1'b1);
        @(negedge reloj);
        chk("wrap_cnt_zero", w_cnt, 16'h0000);
        w_reset = 1'b1;
        @(negedge reloj);
        chk("wrap_rst_cnt",  w_cnt, 16'h0000);
        chk("wrap_rst_link", w_link, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_sched.md
LANE_SCHED -- requirements
Module: lane_sched

Interface
REQ-001 Parameter WORD_W, default 10: serial word width in bits, equal to the serializer word.
REQ-002 Parameter SYNC_WORDS, default 4: comma words sent after link enable; legal range 1..15.
REQ-003 Parameter IDLE_WORD, default 10'b0011111010: comma/idle code (K28.5, RD-).
REQ-004 Ports: reloj  in  1  sole clock, all logic on posedge; reset  in  1  synchronous, active-high.
REQ-005 Ports: link_en  in  1  link enable.
REQ-006 Ports: req0_valid, req1_valid  in  1 each  requester has a word.
REQ-007 Ports: req0_data, req1_data  in  WORD_W each  requester words.
REQ-008 Ports: req0_ready, req1_ready  out  1 each  word accepted this cycle.
REQ-009 Ports: ser_load  out  1  one-cycle pulse; serializer latches ser_word.
REQ-010 Ports: ser_word  out  WORD_W  registered word to serializer.
REQ-011 Ports: link_up  out  1  high while in RUN; word_cnt  out  16  accepted data words, wraps.

Function
REQ-012 Bit counter cnt SHALL free-run 0..WORD_W-1, then wrap to 0; cnt==WORD_W-1 is the "boundary" cycle.
REQ-013 All state transitions, grants and ser_word updates SHALL occur only at a boundary clock edge.
REQ-014 ser_load SHALL be high exactly in cycles where cnt==0 and state at the preceding boundary was SYNC or RUN.
REQ-015 States SHALL be OFF, SYNC, RUN.
REQ-016 OFF->SYNC at boundary when link_en=1; sync_cnt is cleared on entry.
REQ-017 In SYNC, each boundary SHALL load IDLE_WORD and increment sync_cnt; after the SYNC_WORDS-th load, the next state is RUN.
REQ-018 In RUN, each boundary SHALL load the granted requester's data, or IDLE_WORD if neither is valid.
REQ-019 link_en=0 at any boundary SHALL force next state OFF, with no load and no grant; the word already loaded finishes serializing; ser_word holds its value.
REQ-020 reqN_ready SHALL be high only in a RUN boundary cycle for the granted requester: one cycle, at most one ready per boundary.
REQ-021 A transfer occurs iff valid&ready; word_cnt increments by 1 per transfer, wrapping 16'hFFFF->0.
REQ-022 Requesters SHALL hold valid and data stable until ready; valid dropping before a boundary forfeits that slot without error.
REQ-023 Both valid at a boundary: grant per REQ-028; exactly one valid: that requester wins regardless of pointer.
REQ-024 Load latency: data accepted at boundary cycle T appears on ser_word with ser_load in cycle T+1.

Reset
REQ-025 reset SHALL override all inputs, including mid-word and mid-SYNC.
REQ-026 Reset values: cnt=0, state=OFF, sync_cnt=0, ser_word=0, ser_load=0, req0_ready=req1_ready=0, link_up=0, word_cnt=0, rr pointer=req0.
REQ-027 After reset release, the first boundary is the WORD_W-th cycle; no SYNC words are preserved across reset.

Configuration
REQ-028 Macro LANE_SCHED_RR_EN defined: round-robin arbitration, with the pointer moving to the other requester after each grant. Undefined: fixed priority, req0 over req1, with no pointer register.

Structure
REQ-029 Shared package lane_pkg SHALL hold WORD_W default, IDLE_WORD constant and the state encoding (OFF/SYNC/RUN).
REQ-030 Arbitration SHALL sit in sub-module lane_arb (inputs valid[1:0] and advance; output grant[1:0] one-hot or zero); the pointer exists only under LANE_SCHED_RR_EN.

Verification
REQ-031 Reset, then link_en=1 held -> ser_load at cycles 11,21,31,41 with ser_word=IDLE_WORD, then link_up=1.
REQ-032 RUN, RR_EN defined, both valid with 10'h155 and 10'h2AA -> alternating grants 155,2AA,155; word_cnt +1 per boundary.
REQ-033 RUN, RR_EN undefined, both valid -> req0 granted every boundary, req1_ready never high.
REQ-034 RUN, no valid -> IDLE_WORD loaded each boundary, word_cnt unchanged.
REQ-035 link_en dropped mid-word in RUN -> next boundary: no ready, no ser_load, state OFF, link_up=0; re-enable -> 4 SYNC words again.
REQ-036 reset pulsed in SYNC after 2 commas; word_cnt preset to 16'hFFFF plus one transfer wraps to 0 -> all outputs at REQ-026 values next cycle.
